// File: rtl/pam5_trellis_tx.sv
// PAM5 trellis transmitter: scrambles accepted data words with a 33-bit side-stream
// LFSR, trellis-encodes them and maps each 9-bit code word onto four PAM5 lane symbols.
module pam5_trellis_tx #(
  parameter logic [32:0] SCR_SEED      = 33'h1_0000_0001,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_inData,
  input  logic        io_inValid,
  output logic        io_inReady,
  output logic [11:0] io_txSymbols,
  output logic        io_txData
);

  typedef enum logic [1:0] {SETTLE, IDLE, DATA} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [32:0] scr;
  logic [2:0]  cs;      // cs[0]=cs0, cs[1]=cs1, cs[2]=cs2
  logic        accept;
  logic [7:0]  sd;
  logic        sd8;
  logic [11:0] sym_next;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  // Level set picked by the trellis bit; result is the 3-bit two's-complement code.
  function automatic logic [2:0] map_sym(input logic set1, input logic [1:0] c);
    logic [2:0] code;
    case ({set1, c})
      3'b000:  code = 3'b110;
      3'b001:  code = 3'b111;
      3'b010:  code = 3'b001;
      3'b011:  code = 3'b010;
      3'b100:  code = 3'b111;
      3'b101:  code = 3'b000;
      3'b110:  code = 3'b001;
      default: code = 3'b010;
    endcase
    return code;
  endfunction

  always_comb begin
    accept   = io_inValid && io_inReady;
    sd       = (accept ? io_inData : 8'h00) ^ scr[7:0];
    sd8      = cs[0];
    sym_next = {map_sym(sd8, sd[1:0]), map_sym(sd8, sd[3:2]),
                map_sym(sd8, sd[5:4]), map_sym(sd8, sd[7:6])};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= SETTLE;
      cnt          <= '0;
      io_inReady   <= 1'b0;
      scr          <= SCR_SEED;
      cs           <= '0;
      io_txSymbols <= '0;
      io_txData    <= 1'b0;
    end else begin
      scr          <= {scr[31:0], scr[32] ^ scr[12]};
      cs           <= {cs[1] ^ sd[7], cs[0] ^ sd[6], cs[2]};
      io_txSymbols <= sym_next;
      io_txData    <= accept;
      case (state)
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state      <= IDLE;
            io_inReady <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        IDLE: begin
          io_inReady <= 1'b1;
          if (io_inValid) state <= DATA;
        end
        DATA: begin
          io_inReady <= 1'b1;
          if (!io_inValid) state <= IDLE;
        end
        default: begin
          state      <= SETTLE;
          io_inReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pam5_trellis_tx.sv
// Scoreboard bench for pam5_trellis_tx: a transparent-seed instance for the directed
// scenarios and a default-parameter instance for the scrambled soak.
module tb_pam5_trellis_tx;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_z, rst_d, sel_d;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        rdy_z, rdy_d, dat_z, dat_d;
  logic [11:0] sym_z, sym_d;
  logic        obs_rdy, obs_dat;
  logic [11:0] obs_sym;

  pam5_trellis_tx #(.SCR_SEED(33'h0), .SETTLE_CYCLES(4)) u_dut_z (
    .clock(clock), .reset(rst_z), .io_inData(in_data), .io_inValid(in_valid),
    .io_inReady(rdy_z), .io_txSymbols(sym_z), .io_txData(dat_z));

  pam5_trellis_tx #(.SCR_SEED(33'h1_0000_0001), .SETTLE_CYCLES(16)) u_dut_d (
    .clock(clock), .reset(rst_d), .io_inData(in_data), .io_inValid(in_valid),
    .io_inReady(rdy_d), .io_txSymbols(sym_d), .io_txData(dat_d));

  always_comb begin
    obs_rdy = sel_d ? rdy_d : rdy_z;
    obs_sym = sel_d ? sym_d : sym_z;
    obs_dat = sel_d ? dat_d : dat_z;
  end

  typedef struct packed {
    logic [11:0] sym;
    logic        dat;
  } exp_t;
  exp_t sb[$];

  int unsigned n_pass, n_total;

  logic [32:0] m_scr;
  logic [2:0]  m_cs;
  int unsigned m_edges, m_settle;

  function automatic logic [2:0] lvl_code(input logic set1, input logic [1:0] c);
    int lv;
    if (set1) lv = int'(c) - 1;
    else      lv = (c < 2'd2) ? int'(c) - 2 : int'(c) - 1;
    return 3'(lv);
  endfunction

  function automatic logic illegal(input logic [11:0] s);
    logic bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] c = s[i*3 +: 3];
      if (c == 3'b011 || c == 3'b100 || c == 3'b101) bad = 1'b1;
    end
    return bad;
  endfunction

  task automatic restart(input logic which, input logic [32:0] seed, input int unsigned settle);
    sel_d    = which;
    in_valid = 1'b0;
    if (which) rst_d = 1'b1; else rst_z = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    m_scr = seed; m_cs = 3'b000; m_edges = 0; m_settle = settle;
    if (which) rst_d = 1'b0; else rst_z = 1'b0;
  endtask

  // One clock: drive, predict from the model and queue it, then sample after the edge.
  task automatic drive_cycle(input logic v, input logic [7:0] d, output logic exp_rdy,
                             output logic o_rdy, output logic [11:0] o_sym, output logic o_dat);
    exp_t       e;
    logic       acc;
    logic [7:0] sd;
    in_valid = v;
    in_data  = d;
    @(negedge clock);
    o_rdy   = obs_rdy;
    exp_rdy = (m_edges >= m_settle);
    acc     = v && exp_rdy;
    sd      = (acc ? d : 8'h00) ^ m_scr[7:0];
    e.sym   = {lvl_code(m_cs[0], sd[1:0]), lvl_code(m_cs[0], sd[3:2]),
               lvl_code(m_cs[0], sd[5:4]), lvl_code(m_cs[0], sd[7:6])};
    e.dat   = acc;
    sb.push_back(e);
    m_cs    = {m_cs[1] ^ sd[7], m_cs[0] ^ sd[6], m_cs[2]};
    m_scr   = {m_scr[31:0], m_scr[32] ^ m_scr[12]};
    m_edges++;
    @(posedge clock); #1;
    o_sym = obs_sym;
    o_dat = obs_dat;
  endtask

  task automatic test_reset();
    rst_z = 1'b1; rst_d = 1'b1; sel_d = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2;
    n_total++; if (sym_z !== 12'h000) $display("FAIL reset_sym: got %h want 000", sym_z); else n_pass++;
    n_total++; if (dat_z !== 1'b0) $display("FAIL reset_dat: got %b want 0", dat_z); else n_pass++;
    n_total++; if (rdy_z !== 1'b0) $display("FAIL reset_rdy: got %b want 0", rdy_z); else n_pass++;
    n_total++; if (sym_d !== 12'h000) $display("FAIL reset_sym_d: got %h want 000", sym_d); else n_pass++;
  endtask

  task automatic test_settle();
    logic er, r, od;
    logic [11:0] os;
    exp_t e;
    restart(1'b0, 33'h0, 4);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 8'($urandom), er, r, os, od);
      e = sb.pop_front();
      n_total++;
      if (r !== (i >= 4)) $display("FAIL settle_rdy[%0d]: got %b want %b", i, r, (i >= 4)); else n_pass++;
      if (i < 4) begin
        n_total++; if (os !== 12'hDB6) $display("FAIL settle_sym[%0d]: got %h want DB6", i, os); else n_pass++;
        n_total++; if (od !== 1'b0) $display("FAIL settle_dat[%0d]: got %b want 0", i, od); else n_pass++;
      end else begin
        n_total++; if (os !== e.sym) $display("FAIL settle_word_sym[%0d]: got %h want %h", i, os, e.sym); else n_pass++;
        n_total++; if (od !== e.dat) $display("FAIL settle_word_dat[%0d]: got %b want %b", i, od, e.dat); else n_pass++;
      end
    end
  endtask

  // Runs a short directed pattern after settle and checks it against fixed symbols.
  task automatic run_pattern(input string name, input logic [2:0] vs, input logic [23:0] ds,
                             input logic [35:0] want_sym, input logic [2:0] want_dat);
    logic er, r, od;
    logic [11:0] os;
    exp_t e;
    restart(1'b0, 33'h0, 4);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 8'hA5, er, r, os, od);
      e = sb.pop_front();
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(vs[2-i], ds[(2-i)*8 +: 8], er, r, os, od);
      e = sb.pop_front();
      n_total++; if (r !== 1'b1) $display("FAIL %s_rdy[%0d]: got %b want 1", name, i, r); else n_pass++;
      n_total++;
      if (os !== want_sym[(2-i)*12 +: 12])
        $display("FAIL %s_sym[%0d]: got %h want %h", name, i, os, want_sym[(2-i)*12 +: 12]);
      else n_pass++;
      n_total++;
      if (od !== want_dat[2-i]) $display("FAIL %s_dat[%0d]: got %b want %b", name, i, od, want_dat[2-i]);
      else n_pass++;
      n_total++; if (os !== e.sym) $display("FAIL %s_model[%0d]: got %h want %h", name, i, os, e.sym); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    run_pattern("trellis", 3'b111, {8'hFF, 8'hFF, 8'h00}, {12'h492, 12'h492, 12'hFFF}, 3'b111);
  endtask

  task automatic test_gap();
    run_pattern("gap", 3'b101, {8'hFF, 8'h3C, 8'h00}, {12'h492, 12'hDB6, 12'hFFF}, 3'b101);
  endtask

  task automatic test_mid_reset();
    logic er, r, od;
    logic [11:0] os;
    exp_t e;
    restart(1'b0, 33'h0, 4);
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b1, 8'h5A + 8'(i), er, r, os, od);
      e = sb.pop_front();
    end
    in_valid = 1'b1;
    #3 rst_z = 1'b1;
    #1;
    n_total++; if (sym_z !== 12'h000) $display("FAIL midrst_sym: got %h want 000", sym_z); else n_pass++;
    n_total++; if (dat_z !== 1'b0) $display("FAIL midrst_dat: got %b want 0", dat_z); else n_pass++;
    n_total++; if (rdy_z !== 1'b0) $display("FAIL midrst_rdy: got %b want 0", rdy_z); else n_pass++;
    restart(1'b0, 33'h0, 4);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 8'hC3, er, r, os, od);
      e = sb.pop_front();
      n_total++; if (r !== (i >= 4)) $display("FAIL midrst_rdy[%0d]: got %b want %b", i, r, (i >= 4)); else n_pass++;
      if (i == 0) begin
        n_total++; if (os !== 12'hDB6) $display("FAIL midrst_first: got %h want DB6", os); else n_pass++;
      end
      n_total++; if (os !== e.sym) $display("FAIL midrst_model[%0d]: got %h want %h", i, os, e.sym); else n_pass++;
    end
  endtask

  task automatic test_soak();
    logic er, r, od;
    logic [11:0] os;
    exp_t e;
    int unsigned errs = 0;
    restart(1'b1, 33'h1_0000_0001, 16);
    for (int i = 0; i < 10000; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 8'($urandom), er, r, os, od);
      e = sb.pop_front();
      n_total++;
      if (r !== er) begin
        if (errs < 10) $display("FAIL soak_rdy[%0d]: got %b want %b", i, r, er);
        errs++;
      end else n_pass++;
      n_total++;
      if (os !== e.sym || od !== e.dat) begin
        if (errs < 10) $display("FAIL soak_word[%0d]: got %h/%b want %h/%b", i, os, od, e.sym, e.dat);
        errs++;
      end else n_pass++;
      n_total++;
      if (illegal(os) !== 1'b0) begin
        if (errs < 10) $display("FAIL soak_code[%0d]: got %h want legal codes", i, os);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_settle();
    test_back_to_back();
    test_gap();
    test_mid_reset();
    test_soak();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
